chain_ena_sequencer: RTL and testbench
======================================

// Module: chain_ena_sequencer
// PURPOSE
//   Shares one CHAIN_LENGTH-stage enable chain (sense[0..CHAIN_LENGTH].ena) among
//   NREQ requesters. A round-robin arbiter picks the owner, then one-hot walks the
//   stage enable from stage 0 to stage CHAIN_LENGTH. It reports completion or abort.
//   The block sits between the request sources and the stage enables of the chain datapath.
// PARAMETERS
//   CHAIN_LENGTH  4  last stage index; the chain has CHAIN_LENGTH+1 stages (>=1)
//   NREQ          3  number of requesters (>=2); IDW = $clog2(NREQ) (localparam)
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               reset: synchronous, active-low
//   req        in   NREQ            request level per requester; held until done/abort
//   stall      in   1               holds stage advance (used only with CHAIN_STALL_EN)
//   gnt        out  NREQ            one-hot grant; held for the whole run
//   stage_ena  out  CHAIN_LENGTH+1  one-hot stage enable; drives sense[i].ena
//   busy       out  1               high in RUN
//   done       out  1               1-cycle pulse, coincident with stage_ena[CHAIN_LENGTH]
//   abort      out  1               1-cycle pulse: owner dropped req mid-run
//   done_id    out  IDW             owner index; valid with done/abort, held otherwise
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (rst_n low at clk edge): state=IDLE; gnt, stage_ena, busy, done, abort = 0;
//     done_id=0; round-robin pointer=0 (requester 0 has top priority next).
//     Reset asserted mid-run kills the run the next edge; no done or abort is issued.
//   - IDLE: if |req, pick the first set req starting at pointer, wrapping modulo NREQ.
//     Next edge: gnt=onehot(win), stage_ena=1, busy=1, state=RUN, pointer=(win+1)%NREQ.
//     If no req is set, the state stays IDLE.
//   - RUN: stage index s advances by 1 per cycle; stage_ena=1<<s. When s==CHAIN_LENGTH:
//     done=1 and done_id=win in the same cycle. Next edge: IDLE, with all outputs 0
//     except done_id.
//   - Latency: req seen at edge t -> stage_ena[0] at t+1 -> done at t+1+CHAIN_LENGTH.
//     busy stays high for exactly CHAIN_LENGTH+1 cycles.
//   - Back-to-back runs: one mandatory IDLE bubble cycle between runs. Arbitration is
//     performed in that cycle.
//   - Abort: if req[win]==0 is sampled in RUN before the last stage, then next edge:
//     stage_ena=0, gnt=0, busy=0, abort=1, done_id=win, state=IDLE.
//     If req[win]==0 is sampled in the cycle with done=1, done takes priority and no
//     abort is issued.
//   - Requests from non-owners are ignored while in RUN. Their req must stay held.
//   - Invariants: $onehot0(gnt), $onehot0(stage_ena), and busy == |stage_ena.
//   - Arithmetic: stage counter width is $clog2(CHAIN_LENGTH+1); the pointer wraps
//     at NREQ-1 -> 0, including non-power-of-2 NREQ.
// CONFIGURATION
//   CHAIN_STALL_EN defined: stall=1 in RUN freezes s, stage_ena and done for that cycle.
//     done fires only on the cycle the last stage is entered unstalled.
//     Abort detection still operates while stalled. stall is ignored in IDLE.
//   CHAIN_STALL_EN undefined: the stall port is present but ignored.
//     Advance is unconditional, one stage per cycle.
// TESTING  (CHAIN_LENGTH=4, NREQ=3)
//   T1: reset, then req=3'b001 -> gnt=001; stage_ena 01,02,04,08,10 on consecutive
//       cycles; done coincident with 10, done_id=0; busy high 5 cycles.
//   T2: req=3'b111 held continuously -> owners in order 0,1,2,0.
//       Each run is 5 cycles followed by 1 IDLE cycle.
//   T3: req=3'b010 dropped while stage_ena=04 -> next cycle abort=1, done_id=1,
//       stage_ena=0, no done pulse.
//   T4: rst_n=0 while stage_ena=02 -> next cycle all outputs 0, no done or abort.
//       Next grant goes to requester 0.
//   T5: (CHAIN_STALL_EN) stall=1 for 3 cycles at stage_ena=04 -> 04 held 4 cycles total.
//       done arrives 3 cycles later than in T1.
//   T6: owner drops req in the done cycle -> done=1, abort=0.
//       Continuous assertions check one-hot invariants and busy==|stage_ena.

Source files
------------

// File: rtl/chain_ena_sequencer.sv
// Round-robin owner selection plus a one-hot walk of a shared stage-enable chain.
// Optional macro CHAIN_STALL_EN: when defined, stall=1 in RUN freezes the walk.
module chain_ena_sequencer #(
    parameter int CHAIN_LENGTH = 4,
    parameter int NREQ         = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic                          stall,
    output logic [NREQ-1:0]               gnt,
    output logic [CHAIN_LENGTH:0]         stage_ena,
    output logic                          busy,
    output logic                          done,
    output logic                          abort,
    output logic [$clog2(NREQ)-1:0]       done_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = $clog2(CHAIN_LENGTH + 1);
    localparam logic [SW-1:0] LAST    = SW'(CHAIN_LENGTH);
    localparam logic [SW-1:0] LAST_M1 = SW'(CHAIN_LENGTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [NREQ-1:0]       gnt_d;
    logic [CHAIN_LENGTH:0] stage_d;
    logic                  busy_d, done_d, abort_d, advance;
    logic [IDW-1:0]        done_id_d, ptr_q, ptr_d, owner_q, owner_d, win;
    logic [SW-1:0]         s_q, s_d;
    logic                  found;
    int unsigned           arb_idx;

`ifdef CHAIN_STALL_EN
    assign advance = !stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign advance      = 1'b1;
`endif

    // Search starts at the pointer and wraps modulo NREQ, so any NREQ works.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        arb_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[arb_idx]) begin
                found = 1'b1;
                win   = IDW'(arb_idx);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_d   = state_q;
        gnt_d     = '0;
        stage_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        done_id_d = done_id;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        s_d       = s_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    gnt_d   = NREQ'(1) << win;
                    stage_d = (CHAIN_LENGTH+1)'(1);
                    busy_d  = 1'b1;
                    s_d     = '0;
                    owner_d = win;
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
            RUN: begin
                if (s_q == LAST) begin
                    // Done cycle: return to IDLE even if the owner dropped req now.
                    state_d = IDLE;
                end else if (!req[owner_q]) begin
                    state_d   = IDLE;
                    abort_d   = 1'b1;
                    done_id_d = owner_q;
                end else begin
                    gnt_d  = gnt;
                    busy_d = 1'b1;
                    if (advance) begin
                        s_d     = s_q + 1'b1;
                        stage_d = stage_ena << 1;
                        if (s_q == LAST_M1) begin
                            done_d    = 1'b1;
                            done_id_d = owner_q;
                        end
                    end else begin
                        stage_d = stage_ena;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            stage_ena <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            done_id   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            s_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            stage_ena <= stage_d;
            busy      <= busy_d;
            done      <= done_d;
            abort     <= abort_d;
            done_id   <= done_id_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            s_q       <= s_d;
        end
    end

endmodule

// File: tb/tb_chain_ena_sequencer.sv
// Directed bench for chain_ena_sequencer (CHAIN_LENGTH=4, NREQ=3); invariants checked every cycle.
module tb_chain_ena_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       stall;
    logic [2:0] gnt;
    logic [4:0] stage_ena;
    logic       busy, done, abort;
    logic [1:0] done_id;

    int n_checks = 0;
    int n_pass   = 0;

    chain_ena_sequencer #(.CHAIN_LENGTH(4), .NREQ(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .stall     (stall),
        .gnt       (gnt),
        .stage_ena (stage_ena),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .done_id   (done_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Advance one clock, sample 1 time unit after the edge, check invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot_gnt", 32'($onehot0(gnt)), 1);
        check("onehot_stage", 32'($onehot0(stage_ena)), 1);
        check("busy_vs_stage", 32'(busy), 32'(|stage_ena));
    endtask

    task automatic expect_stage(input string tag, input int k, input int owner);
        check({tag, "_stage"}, 32'(stage_ena), 32'(1 << k));
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << owner));
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_done"}, 32'(done), (k == 4) ? 1 : 0);
        check({tag, "_abort"}, 32'(abort), 0);
        if (k == 4) check({tag, "_done_id"}, 32'(done_id), 32'(owner));
    endtask

    task automatic expect_run(input string tag, input int owner);
        for (int k = 0; k <= 4; k++) begin
            tick();
            expect_stage(tag, k, owner);
        end
    endtask

    task automatic expect_idle(input string tag, input int id);
        check({tag, "_idle_stage"}, 32'(stage_ena), 0);
        check({tag, "_idle_gnt"}, 32'(gnt), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_done"}, 32'(done), 0);
        check({tag, "_idle_abort"}, 32'(abort), 0);
        check({tag, "_idle_done_id"}, 32'(done_id), 32'(id));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        req   = '0;
        stall = 1'b0;
        do_reset();
        expect_idle("reset", 0);

        // T1: single requester 0, full walk.
        req = 3'b001;
        expect_run("t1", 0);
        req = 3'b000;
        tick();
        expect_idle("t1", 0);

        // T2: all requesting from a fresh reset, owners 0,1,2,0 with one bubble each.
        do_reset();
        req = 3'b111;
        expect_run("t2_r0", 0);
        tick(); expect_idle("t2_b0", 0);
        expect_run("t2_r1", 1);
        tick(); expect_idle("t2_b1", 1);
        expect_run("t2_r2", 2);
        tick(); expect_idle("t2_b2", 2);
        expect_run("t2_r3", 0);
        // T6: owner drops req during its done cycle -> no abort afterwards.
        req = 3'b000;
        tick();
        expect_idle("t6a", 0);

        // T3: requester 1 drops req at stage 2 (pointer is 1 here).
        req = 3'b010;
        tick(); expect_stage("t3", 0, 1);
        tick(); expect_stage("t3", 1, 1);
        tick(); expect_stage("t3", 2, 1);
        req = 3'b000;
        tick();
        check("t3_abort", 32'(abort), 1);
        check("t3_done_id", 32'(done_id), 1);
        check("t3_stage", 32'(stage_ena), 0);
        check("t3_gnt", 32'(gnt), 0);
        check("t3_done", 32'(done), 0);
        tick();
        expect_idle("t3", 1);

        // T4: reset mid-run; pointer returns to 0 (otherwise 2 would win req=101).
        req = 3'b010;
        tick(); expect_stage("t4", 0, 1);
        tick(); expect_stage("t4", 1, 1);
        rst_n = 1'b0;
        tick();
        expect_idle("t4_rst", 0);
        rst_n = 1'b1;
        req   = 3'b101;
        expect_run("t4_after", 0);
        req = 3'b000;
        tick();
        expect_idle("t4", 0);

        // T5: stall at stage 2 (pointer is 1 here, only requester 0 asks).
        req = 3'b001;
        tick(); expect_stage("t5", 0, 0);
        tick(); expect_stage("t5", 1, 0);
        tick(); expect_stage("t5", 2, 0);
        stall = 1'b1;
`ifdef CHAIN_STALL_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_stage("t5_hold", 2, 0);
        end
        stall = 1'b0;
        tick(); expect_stage("t5", 3, 0);
        tick(); expect_stage("t5", 4, 0);
`else
        tick(); expect_stage("t5_ign", 3, 0);
        tick(); expect_stage("t5_ign", 4, 0);
        stall = 1'b0;
`endif
        req = 3'b000;
        tick();
        expect_idle("t5", 0);

        // T6 again with a non-zero owner (pointer is 1).
        req = 3'b010;
        expect_run("t6", 1);
        req = 3'b000;
        tick();
        expect_idle("t6b", 1);
        tick();
        expect_idle("t6c", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
